mem_arbiter: RTL

// Shares the byte-banked (even/odd) memory between two byte-addressed requesters: A (CPU) and B (debug/loader).

---
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for an even/odd byte-banked memory.
// Round-robin grant, byte/word split across banks, ROM write protect.
module mem_arbiter #(
  parameter logic [15:0] ROMBASE = 16'h4000,
  parameter bit          ROMWP   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [15:0] a_addr,
  input  logic        a_we,
  input  logic        a_word,
  input  logic [15:0] a_wdata,
  input  logic        b_req,
  input  logic [15:0] b_addr,
  input  logic        b_we,
  input  logic        b_word,
  input  logic [15:0] b_wdata,
  output logic        a_gnt,
  output logic        b_gnt,
  output logic        a_rvalid,
  output logic        b_rvalid,
  output logic [15:0] a_rdata,
  output logic [15:0] b_rdata,
  output logic        a_err,
  output logic        b_err,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd,
  output logic [14:0] write_addr_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd
);

  logic        r_last_b;
  logic [14:0] r_ra_even, r_ra_odd;
  logic [14:0] r_wa_even, r_wa_odd;
  logic [7:0]  r_wd_even, r_wd_odd;
  logic        r_rv, r_own_b, r_tag_odd, r_tag_word;
  logic        r_a_err, r_b_err;

  logic        w_a_gnt, w_b_gnt, w_gnt;
  logic [15:0] w_addr, w_wdata, w_next;
  logic        w_we, w_word;
  logic [14:0] w_w, w_w1, w_ev_addr;
  logic        w_rd, w_wr, w_rom, w_drop;
  logic        w_touch_ev, w_touch_od;
  logic [7:0]  w_wd_ev, w_wd_od;
  logic [7:0]  w_lo, w_hi;

  // r_last_b = 1 means B won last, so A wins the next tie
  assign w_a_gnt = ~reset & a_req & (~b_req | r_last_b);
  assign w_b_gnt = ~reset & b_req & (~a_req | ~r_last_b);
  assign w_gnt   = w_a_gnt | w_b_gnt;

  assign w_addr  = w_b_gnt ? b_addr  : a_addr;
  assign w_we    = w_b_gnt ? b_we    : a_we;
  assign w_word  = w_b_gnt ? b_word  : a_word;
  assign w_wdata = w_b_gnt ? b_wdata : a_wdata;

  assign w_w       = w_addr[15:1];
  assign w_w1      = w_w + 15'd1;
  assign w_ev_addr = w_addr[0] ? w_w1 : w_w;
  assign w_next    = w_addr + 16'd1;

  assign w_rd = w_gnt & ~w_we;
  assign w_wr = w_gnt & w_we;

  assign w_rom  = (w_addr >= ROMBASE) | (w_word & (w_next >= ROMBASE));
  assign w_drop = ROMWP & w_rom;

  assign w_touch_ev = w_word | ~w_addr[0];
  assign w_touch_od = w_word | w_addr[0];
  assign w_wd_ev    = w_addr[0] ? w_wdata[15:8] : w_wdata[7:0];
  assign w_wd_od    = w_addr[0] ? w_wdata[7:0]  : w_wdata[15:8];

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  assign read_addr_even  = w_rd ? w_ev_addr : r_ra_even;
  assign read_addr_odd   = w_rd ? w_w       : r_ra_odd;
  assign write_addr_even = w_wr ? w_ev_addr : r_wa_even;
  assign write_addr_odd  = w_wr ? w_w       : r_wa_odd;
  assign write_data_even = w_wr ? w_wd_ev   : r_wd_even;
  assign write_data_odd  = w_wr ? w_wd_od   : r_wd_odd;
  assign write_en_even   = w_wr & ~w_drop & w_touch_ev;
  assign write_en_odd    = w_wr & ~w_drop & w_touch_od;

  assign w_lo = r_tag_odd ? read_data_odd : read_data_even;
  assign w_hi = ~r_tag_word ? 8'h00 :
                (r_tag_odd ? read_data_even : read_data_odd);

  assign a_rvalid = r_rv & ~r_own_b;
  assign b_rvalid = r_rv & r_own_b;
  assign a_rdata  = a_rvalid ? {w_hi, w_lo} : 16'h0000;
  assign b_rdata  = b_rvalid ? {w_hi, w_lo} : 16'h0000;
  assign a_err    = r_a_err;
  assign b_err    = r_b_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_b   <= 1'b1;
      r_ra_even  <= '0;
      r_ra_odd   <= '0;
      r_wa_even  <= '0;
      r_wa_odd   <= '0;
      r_wd_even  <= '0;
      r_wd_odd   <= '0;
      r_rv       <= 1'b0;
      r_own_b    <= 1'b0;
      r_tag_odd  <= 1'b0;
      r_tag_word <= 1'b0;
      r_a_err    <= 1'b0;
      r_b_err    <= 1'b0;
    end else begin
      if (w_gnt)
        r_last_b <= w_b_gnt;
      if (w_rd) begin
        r_ra_even <= w_ev_addr;
        r_ra_odd  <= w_w;
      end
      if (w_wr) begin
        r_wa_even <= w_ev_addr;
        r_wa_odd  <= w_w;
        r_wd_even <= w_wd_ev;
        r_wd_odd  <= w_wd_od;
      end
      // read tag steers bank bytes back to the owner next cycle
      r_rv       <= w_rd;
      r_own_b    <= w_b_gnt;
      r_tag_odd  <= w_addr[0];
      r_tag_word <= w_word;
      r_a_err    <= w_wr & w_drop & w_a_gnt;
      r_b_err    <= w_wr & w_drop & w_b_gnt;
    end
  end

endmodule
